// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage. It owns the sample counter and the butterfly.
// It also routes data to and from an external DEPTH-deep shift buffer.
module r2sdf_bf_stage #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 8,
    parameter int SCALE  = 0
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData_Re,
    input  logic [DATA_W-1:0] iData_Im,
    input  logic [DATA_W-1:0] iFb_Re,
    input  logic [DATA_W-1:0] iFb_Im,
    output logic              oFb_En,
    output logic [DATA_W-1:0] oFb_Re,
    output logic [DATA_W-1:0] oFb_Im,
    output logic              oValid,
    output logic              oFirst,
    output logic [DATA_W-1:0] oData_Re,
    output logic [DATA_W-1:0] oData_Im
);
    localparam int CNT_W = $clog2(2 * DEPTH);
    localparam logic [CNT_W-1:0] CNT_BFLY = CNT_W'(DEPTH);

    logic [CNT_W-1:0] cnt;
    logic             primed;
    logic             bfly;
    logic             atBfly;
    logic             emit;
    logic [DATA_W:0]  sumRe;
    logic [DATA_W:0]  sumIm;
    logic [DATA_W:0]  diffRe;
    logic [DATA_W:0]  diffIm;
    logic [DATA_W-1:0] candRe;
    logic [DATA_W-1:0] candIm;

    // Either halve with floor (keeps the stage from growing) or wrap to DATA_W.
    function automatic logic [DATA_W-1:0] fitWidth(input logic [DATA_W:0] v);
        if (SCALE != 0)
            return v[DATA_W:1];
        else
            return v[DATA_W-1:0];
    endfunction

    assign bfly   = cnt[CNT_W-1];
    assign atBfly = (cnt == CNT_BFLY);
    assign emit   = primed | atBfly;

    assign sumRe  = {iFb_Re[DATA_W-1], iFb_Re} + {iData_Re[DATA_W-1], iData_Re};
    assign sumIm  = {iFb_Im[DATA_W-1], iFb_Im} + {iData_Im[DATA_W-1], iData_Im};
    assign diffRe = {iFb_Re[DATA_W-1], iFb_Re} - {iData_Re[DATA_W-1], iData_Re};
    assign diffIm = {iFb_Im[DATA_W-1], iFb_Im} - {iData_Im[DATA_W-1], iData_Im};

    assign oFb_En = iValid;
    assign oFb_Re = bfly ? fitWidth(diffRe) : iData_Re;
    assign oFb_Im = bfly ? fitWidth(diffIm) : iData_Im;
    assign candRe = bfly ? fitWidth(sumRe) : iFb_Re;
    assign candIm = bfly ? fitWidth(sumIm) : iFb_Im;

    // Until the first butterfly phase, the buffer content is stale, so FILL samples are not emitted.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt      <= '0;
            primed   <= 1'b0;
            oValid   <= 1'b0;
            oFirst   <= 1'b0;
            oData_Re <= '0;
            oData_Im <= '0;
        end else if (iValid) begin
            cnt    <= cnt + 1'b1;
            oValid <= emit;
            oFirst <= atBfly;
            if (atBfly)
                primed <= 1'b1;
            if (emit) begin
                oData_Re <= candRe;
                oData_Im <= candIm;
            end
        end else begin
            oValid <= 1'b0;
            oFirst <= 1'b0;
        end
    end
endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Bench for r2sdf_bf_stage: SCALE=0 and SCALE=1 instances share stimulus, each with its own feedback buffer.
// Expected outputs come from a frame-level radix-2 DIF model over the recorded input history.
module tb_r2sdf_bf_stage;
    localparam int DATA_W = 35;
    localparam int DEPTH  = 8;

    logic iClk;
    logic iRst_n;
    logic iValid;
    logic [DATA_W-1:0] iData_Re, iData_Im;

    logic fbEn0, fbEn1;
    logic [DATA_W-1:0] fbW0Re, fbW0Im, fbW1Re, fbW1Im;
    logic oValid0, oFirst0, oValid1, oFirst1;
    logic [DATA_W-1:0] d0Re, d0Im, d1Re, d1Im;

    logic [DATA_W-1:0] buf0Re[DEPTH];
    logic [DATA_W-1:0] buf0Im[DEPTH];
    logic [DATA_W-1:0] buf1Re[DEPTH];
    logic [DATA_W-1:0] buf1Im[DEPTH];

    int nChecks = 0;
    int nPass   = 0;

    longint xRe[$];
    longint xIm[$];
    logic eV, eF;
    logic [DATA_W-1:0] e0Re, e0Im, e1Re, e1Im;

    r2sdf_bf_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SCALE(0)) u_dut0 (
        .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid),
        .iData_Re(iData_Re), .iData_Im(iData_Im),
        .iFb_Re(buf0Re[DEPTH-1]), .iFb_Im(buf0Im[DEPTH-1]),
        .oFb_En(fbEn0), .oFb_Re(fbW0Re), .oFb_Im(fbW0Im),
        .oValid(oValid0), .oFirst(oFirst0), .oData_Re(d0Re), .oData_Im(d0Im)
    );

    r2sdf_bf_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SCALE(1)) u_dut1 (
        .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid),
        .iData_Re(iData_Re), .iData_Im(iData_Im),
        .iFb_Re(buf1Re[DEPTH-1]), .iFb_Im(buf1Im[DEPTH-1]),
        .oFb_En(fbEn1), .oFb_Re(fbW1Re), .oFb_Im(fbW1Im),
        .oValid(oValid1), .oFirst(oFirst1), .oData_Re(d1Re), .oData_Im(d1Im)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // External delay lines (buffer_8 stand-ins), never reset.
    always @(posedge iClk) begin
        if (fbEn0) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                buf0Re[i] <= buf0Re[i-1];
                buf0Im[i] <= buf0Im[i-1];
            end
            buf0Re[0] <= fbW0Re;
            buf0Im[0] <= fbW0Im;
        end
        if (fbEn1) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                buf1Re[i] <= buf1Re[i-1];
                buf1Im[i] <= buf1Im[i-1];
            end
            buf1Re[0] <= fbW1Re;
            buf1Im[0] <= fbW1Im;
        end
    end

    function automatic logic [DATA_W-1:0] bfOut(input longint a, input longint b,
                                                 input bit isSum, input bit scale);
        longint r;
        r = isSum ? a + b : a - b;
        if (scale)
            r = r >>> 1;
        return r[DATA_W-1:0];
    endfunction

    function automatic longint rand35();
        longint r;
        r = {$urandom(), $urandom()};
        r = r <<< (64 - DATA_W);
        return r >>> (64 - DATA_W);
    endfunction

    // Applies one cycle of stimulus and updates the expected outputs.
    // Within each 2*DEPTH frame, sample k+DEPTH yields x[k]+x[k+DEPTH].
    // Sample k of the next frame yields x[k]-x[k+DEPTH] of the previous frame.
    task automatic step(input bit rst, input bit v, input longint re, input longint im);
        int n, p;
        longint aRe, bRe, aIm, bIm;
        bit isSum;
        iRst_n   = !rst;
        iValid   = v;
        iData_Re = re[DATA_W-1:0];
        iData_Im = im[DATA_W-1:0];
        eV = 1'b0;
        eF = 1'b0;
        if (rst) begin
            xRe.delete();
            xIm.delete();
            e0Re = '0; e0Im = '0; e1Re = '0; e1Im = '0;
        end else if (v) begin
            n = xRe.size();
            p = n % (2 * DEPTH);
            isSum = 1'b0;
            aRe = 0; bRe = 0; aIm = 0; bIm = 0;
            if (p >= DEPTH) begin
                aRe = xRe[n-DEPTH]; aIm = xIm[n-DEPTH];
                bRe = re;           bIm = im;
                isSum = 1'b1;
                eV = 1'b1;
                eF = (p == DEPTH);
            end else if (n >= 2 * DEPTH) begin
                aRe = xRe[n-2*DEPTH]; aIm = xIm[n-2*DEPTH];
                bRe = xRe[n-DEPTH];   bIm = xIm[n-DEPTH];
                eV = 1'b1;
            end
            if (eV) begin
                e0Re = bfOut(aRe, bRe, isSum, 1'b0);
                e0Im = bfOut(aIm, bIm, isSum, 1'b0);
                e1Re = bfOut(aRe, bRe, isSum, 1'b1);
                e1Im = bfOut(aIm, bIm, isSum, 1'b1);
            end
            xRe.push_back(re);
            xIm.push_back(im);
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 5, 7);
            nChecks++;
            if ({oValid0, oFirst0, oValid1, oFirst1} !== 4'b0000)
                $display("FAIL reset_ctrl got v0f0v1f1=%b%b%b%b need 0000", oValid0, oFirst0, oValid1, oFirst1);
            else nPass++;
            nChecks++;
            if ({d0Re, d0Im, d1Re, d1Im} !== '0)
                $display("FAIL reset_data got %0d %0d %0d %0d need 0", d0Re, d0Im, d1Re, d1Im);
            else nPass++;
        end
    endtask

    task automatic test_ramp();
        step(1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 24; i++) begin
            step(1'b0, 1'b1, i, 0);
            nChecks++;
            if ({oValid0, oFirst0, oValid1, oFirst1} !== {eV, eF, eV, eF})
                $display("FAIL ramp_ctrl in=%0d got v0f0v1f1=%b%b%b%b need v=%b f=%b", i, oValid0, oFirst0, oValid1, oFirst1, eV, eF);
            else nPass++;
            nChecks++;
            if ({d0Re, d0Im, d1Re, d1Im} !== {e0Re, e0Im, e1Re, e1Im})
                $display("FAIL ramp_data in=%0d got %0d/%0d need %0d/%0d", i, $signed(d0Re), $signed(d1Re), $signed(e0Re), $signed(e1Re));
            else nPass++;
        end
    endtask

    task automatic test_stall();
        int idx = 1;
        int cyc = 0;
        step(1'b1, 1'b0, 0, 0);
        while (idx <= 24) begin
            if (cyc % 3 == 2)
                step(1'b0, 1'b0, 0, 0);
            else begin
                step(1'b0, 1'b1, idx, 0);
                idx++;
            end
            cyc++;
            nChecks++;
            if ({fbEn0, fbEn1} !== {iValid, iValid})
                $display("FAIL stall_fben cyc=%0d got %b%b need %b", cyc, fbEn0, fbEn1, iValid);
            else nPass++;
            nChecks++;
            if ({oValid0, oFirst0, oValid1, oFirst1} !== {eV, eF, eV, eF})
                $display("FAIL stall_ctrl cyc=%0d got v0f0v1f1=%b%b%b%b need v=%b f=%b", cyc, oValid0, oFirst0, oValid1, oFirst1, eV, eF);
            else nPass++;
            nChecks++;
            if ({d0Re, d0Im, d1Re, d1Im} !== {e0Re, e0Im, e1Re, e1Im})
                $display("FAIL stall_data cyc=%0d got %0d/%0d need %0d/%0d", cyc, $signed(d0Re), $signed(d1Re), $signed(e0Re), $signed(e1Re));
            else nPass++;
        end
    endtask

    task automatic test_overflow();
        longint big = (longint'(1) <<< 34) - 1;
        step(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, (i < 16) ? big : 0, 0);
            nChecks++;
            if ({oValid0, oFirst0, oValid1, oFirst1} !== {eV, eF, eV, eF})
                $display("FAIL ovf_ctrl i=%0d got v0f0v1f1=%b%b%b%b need v=%b f=%b", i, oValid0, oFirst0, oValid1, oFirst1, eV, eF);
            else nPass++;
            nChecks++;
            if ({d0Re, d0Im, d1Re, d1Im} !== {e0Re, e0Im, e1Re, e1Im})
                $display("FAIL ovf_data i=%0d got %0d/%0d need %0d/%0d", i, $signed(d0Re), $signed(d1Re), $signed(e0Re), $signed(e1Re));
            else nPass++;
        end
    endtask

    task automatic test_imag();
        step(1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 24; i++) begin
            step(1'b0, 1'b1, 0, -i);
            nChecks++;
            if ({oValid0, oFirst0, oValid1, oFirst1} !== {eV, eF, eV, eF})
                $display("FAIL imag_ctrl in=%0d got v0f0v1f1=%b%b%b%b need v=%b f=%b", i, oValid0, oFirst0, oValid1, oFirst1, eV, eF);
            else nPass++;
            nChecks++;
            if ({d0Re, d0Im, d1Re, d1Im} !== {e0Re, e0Im, e1Re, e1Im})
                $display("FAIL imag_data in=%0d got re=%0d im=%0d need re=%0d im=%0d", i, $signed(d0Re), $signed(d0Im), $signed(e0Re), $signed(e0Im));
            else nPass++;
        end
    endtask

    task automatic test_midframe_reset();
        step(1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 12; i++)
            step(1'b0, 1'b1, i * 3, i);
        step(1'b1, 1'b1, 99, 99);
        nChecks++;
        if ({oValid0, oValid1, d0Re, d0Im, d1Re, d1Im} !== '0)
            $display("FAIL midrst_clear got v=%b%b re=%0d/%0d need all 0", oValid0, oValid1, $signed(d0Re), $signed(d1Re));
        else nPass++;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, i, 0);
            nChecks++;
            if ({oValid0, oFirst0, oValid1, oFirst1} !== {eV, eF, eV, eF})
                $display("FAIL midrst_ctrl in=%0d got v0f0v1f1=%b%b%b%b need v=%b f=%b", i, oValid0, oFirst0, oValid1, oFirst1, eV, eF);
            else nPass++;
            nChecks++;
            if ({d0Re, d0Im, d1Re, d1Im} !== {e0Re, e0Im, e1Re, e1Im})
                $display("FAIL midrst_data in=%0d got %0d/%0d need %0d/%0d", i, $signed(d0Re), $signed(d1Re), $signed(e0Re), $signed(e1Re));
            else nPass++;
        end
    endtask

    task automatic test_random_frames();
        int sent = 0;
        step(1'b1, 1'b0, 0, 0);
        while (sent < 4 * 2 * DEPTH + DEPTH) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b0, 1'b0, rand35(), rand35());
            else begin
                step(1'b0, 1'b1, rand35(), rand35());
                sent++;
            end
            nChecks++;
            if ({oValid0, oFirst0, oValid1, oFirst1} !== {eV, eF, eV, eF})
                $display("FAIL rand_ctrl n=%0d got v0f0v1f1=%b%b%b%b need v=%b f=%b", sent, oValid0, oFirst0, oValid1, oFirst1, eV, eF);
            else nPass++;
            nChecks++;
            if ({d0Re, d0Im, d1Re, d1Im} !== {e0Re, e0Im, e1Re, e1Im})
                $display("FAIL rand_data n=%0d got %h %h %h %h need %h %h %h %h", sent, d0Re, d0Im, d1Re, d1Im, e0Re, e0Im, e1Re, e1Im);
            else nPass++;
        end
    endtask

    initial begin
        iRst_n   = 1'b0;
        iValid   = 1'b0;
        iData_Re = '0;
        iData_Im = '0;
        test_reset();
        test_ramp();
        test_stall();
        test_overflow();
        test_imag();
        test_midframe_reset();
        test_random_frames();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
